// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory request/ready handshake,
// aligns/extends load data and registers results into the MEM/WB boundary.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned FLEN = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [31:0]     PC_I,
  input  logic [XLEN-1:0] alu_result_I,
  input  logic [XLEN-1:0] store_to_mem_I,
  input  logic            MEM_Rd_En_I,
  input  logic            MEM_Wr_En_I,
  input  logic            LB_I,
  input  logic            LH_I,
  input  logic            SB_I,
  input  logic            SH_I,
  input  logic            LU_I,
  input  logic            RegI_Wr_En_I,
  input  logic            RegF_Wr_En_I,
  input  logic [1:0]      iSrc_to_Reg_I,
  input  logic            fSrc_to_Reg_I,
  input  logic [4:0]      ex_mem_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [31:0]     PC_O,
  output logic [XLEN-1:0] load_data_O,
  output logic [XLEN-1:0] alu_result_O,
  output logic            RegI_Wr_En_O,
  output logic            RegF_Wr_En_O,
  output logic [1:0]      iSrc_to_Reg_O,
  output logic            fSrc_to_Reg_O,
  output logic [4:0]      mem_wb_rd,
  output logic            misalign_O
);

  localparam int unsigned BEW = 4;

  // FP width only shapes the writeback controls; a zero width is meaningless.
  if (FLEN == 0) begin : g_flen_zero
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;

  logic            mem_op_c, is_store_c, is_byte_c, is_half_c, is_word_c;
  logic            misalign_c, go_c;
  logic [1:0]      off_c;
  logic [BEW-1:0]  be_c;
  logic [XLEN-1:0] wdata_c;

  logic [31:0]     lat_pc;
  logic [XLEN-1:0] lat_alu, lat_data;
  logic            lat_regi, lat_regf, lat_fsrc, lat_load, lat_byte, lat_half, lat_lu;
  logic [1:0]      lat_isrc, lat_off;
  logic [4:0]      lat_rd;

  logic [4:0]      shamt_c;
  logic [XLEN-1:0] rsh_c, ext_c;

  // Access decode, alignment check and store lane placement.
  always_comb begin
    mem_op_c   = MEM_Rd_En_I | MEM_Wr_En_I;
    is_store_c = MEM_Wr_En_I;
    is_byte_c  = LB_I | SB_I;
    is_half_c  = ~is_byte_c & (LH_I | SH_I);
    is_word_c  = ~is_byte_c & ~is_half_c;
    off_c      = alu_result_I[1:0];
    misalign_c = mem_op_c & ((is_half_c & off_c[0]) | (is_word_c & (off_c != 2'b00)));
    go_c       = mem_op_c & ~misalign_c;
    be_c       = 4'b1111;
    wdata_c    = store_to_mem_I;
    if (is_byte_c) begin
      be_c    = 4'(1) << off_c;
      wdata_c = XLEN'({4{store_to_mem_I[7:0]}});
    end else if (is_half_c) begin
      be_c    = off_c[1] ? 4'b1100 : 4'b0011;
      wdata_c = XLEN'({2{store_to_mem_I[15:0]}});
    end
  end

  // Load lane extraction and sign/zero extension from the latched access shape.
  always_comb begin
    shamt_c = lat_half ? {lat_off[1], 4'b0000} : {lat_off, 3'b000};
    rsh_c   = dmem_rdata >> shamt_c;
    ext_c   = rsh_c;
    if (lat_byte)
      ext_c = {{(XLEN-8){~lat_lu & rsh_c[7]}}, rsh_c[7:0]};
    else if (lat_half)
      ext_c = {{(XLEN-16){~lat_lu & rsh_c[15]}}, rsh_c[15:0]};
  end

  always_ff @(posedge CLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: if (go_c) begin
        mem_stall = 1'b1;
        state_nx  = S_REQ;
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (dmem_ready) state_nx = lat_load ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request registers, EX/MEM latches and MEM/WB outputs; bubble unless written below.
  always_ff @(posedge CLK) begin
    if (rst) begin
      dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_addr <= '0; dmem_wdata <= '0; dmem_be <= '0;
      lat_pc <= '0; lat_alu <= '0; lat_data <= '0; lat_regi <= 1'b0; lat_regf <= 1'b0;
      lat_fsrc <= 1'b0; lat_load <= 1'b0; lat_byte <= 1'b0; lat_half <= 1'b0; lat_lu <= 1'b0;
      lat_isrc <= '0; lat_off <= '0; lat_rd <= '0;
      PC_O <= '0; load_data_O <= '0; alu_result_O <= '0; RegI_Wr_En_O <= 1'b0;
      RegF_Wr_En_O <= 1'b0; iSrc_to_Reg_O <= '0; fSrc_to_Reg_O <= 1'b0; mem_wb_rd <= '0;
      misalign_O <= 1'b0;
    end else begin
      RegI_Wr_En_O <= 1'b0;
      RegF_Wr_En_O <= 1'b0;
      misalign_O   <= 1'b0;
      load_data_O  <= '0;
      case (state)
        S_IDLE: begin
          if (go_c) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store_c;
            dmem_addr  <= {alu_result_I[XLEN-1:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            lat_pc   <= PC_I;          lat_alu  <= alu_result_I;
            lat_regi <= RegI_Wr_En_I;  lat_regf <= RegF_Wr_En_I;
            lat_isrc <= iSrc_to_Reg_I; lat_fsrc <= fSrc_to_Reg_I;
            lat_rd   <= ex_mem_rd;     lat_load <= ~is_store_c;
            lat_byte <= is_byte_c;     lat_half <= is_half_c;
            lat_lu   <= LU_I;          lat_off  <= off_c;
          end else begin
            PC_O          <= PC_I;
            alu_result_O  <= alu_result_I;
            RegI_Wr_En_O  <= RegI_Wr_En_I & ~misalign_c;
            RegF_Wr_En_O  <= RegF_Wr_En_I & ~misalign_c;
            iSrc_to_Reg_O <= iSrc_to_Reg_I;
            fSrc_to_Reg_O <= fSrc_to_Reg_I;
            mem_wb_rd     <= ex_mem_rd;
            misalign_O    <= misalign_c;
          end
        end
        S_REQ:  if (dmem_ready) dmem_req <= 1'b0;
        S_WAIT: if (dmem_rvalid) lat_data <= ext_c;
        S_DONE: begin
          PC_O          <= lat_pc;
          alu_result_O  <= lat_alu;
          RegI_Wr_En_O  <= lat_regi;
          RegF_Wr_En_O  <= lat_regf;
          iSrc_to_Reg_O <= lat_isrc;
          fSrc_to_Reg_O <= lat_fsrc;
          mem_wb_rd     <= lat_rd;
          load_data_O   <= lat_load ? lat_data : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: byte-level reference memory, random
// memory latencies, and decoupled request/writeback monitors.
module tb_mem_stage_lsu;
  localparam int unsigned XLEN = 32;

  logic            CLK, rst;
  logic [31:0]     PC_I;
  logic [XLEN-1:0] alu_result_I, store_to_mem_I;
  logic            MEM_Rd_En_I, MEM_Wr_En_I, LB_I, LH_I, SB_I, SH_I, LU_I;
  logic            RegI_Wr_En_I, RegF_Wr_En_I, fSrc_to_Reg_I;
  logic [1:0]      iSrc_to_Reg_I;
  logic [4:0]      ex_mem_rd;
  logic            dmem_req, dmem_we, dmem_ready, dmem_rvalid, mem_stall;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;
  logic [31:0]     PC_O;
  logic [XLEN-1:0] load_data_O, alu_result_O;
  logic            RegI_Wr_En_O, RegF_Wr_En_O, fSrc_to_Reg_O, misalign_O;
  logic [1:0]      iSrc_to_Reg_O;
  logic [4:0]      mem_wb_rd;

  mem_stage_lsu #(.XLEN(32), .FLEN(32)) dut (
    .CLK(CLK), .rst(rst), .PC_I(PC_I), .alu_result_I(alu_result_I),
    .store_to_mem_I(store_to_mem_I), .MEM_Rd_En_I(MEM_Rd_En_I), .MEM_Wr_En_I(MEM_Wr_En_I),
    .LB_I(LB_I), .LH_I(LH_I), .SB_I(SB_I), .SH_I(SH_I), .LU_I(LU_I),
    .RegI_Wr_En_I(RegI_Wr_En_I), .RegF_Wr_En_I(RegF_Wr_En_I), .iSrc_to_Reg_I(iSrc_to_Reg_I),
    .fSrc_to_Reg_I(fSrc_to_Reg_I), .ex_mem_rd(ex_mem_rd), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .PC_O(PC_O), .load_data_O(load_data_O), .alu_result_O(alu_result_O),
    .RegI_Wr_En_O(RegI_Wr_En_O), .RegF_Wr_En_O(RegF_Wr_En_O), .iSrc_to_Reg_O(iSrc_to_Reg_O),
    .fSrc_to_Reg_O(fSrc_to_Reg_O), .mem_wb_rd(mem_wb_rd), .misalign_O(misalign_O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, alu, ld;
    logic        regi, regf, fsrc, mis;
    logic [1:0]  isrc;
    logic [4:0]  rd;
  } wb_t;
  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } rq_t;
  typedef struct {
    logic [31:0] pc, addr, sdata;
    logic        rd_en, wr_en, lu, regi, regf, fsrc;
    logic [1:0]  isrc;
    logic [4:0]  rd;
    int          size;
  } op_t;

  wb_t         wb_q[$];
  rq_t         rq_q[$];
  logic [7:0]  ref_mem [256];
  logic [31:0] dmem [64];
  int          n_cmp = 0, n_bad = 0;
  logic        hold_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback monitor: every MEM/WB write or misalign flag must match the next expected record.
  initial begin
    wb_t e;
    forever begin
      @(negedge CLK);
      if (!rst && (RegI_Wr_En_O || RegF_Wr_En_O || misalign_O)) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_unexpected: got pc %08h rd %0d mis %0b expected none", PC_O, mem_wb_rd, misalign_O);
        end else begin
          e = wb_q.pop_front();
          check("wb_misalign", 32'(misalign_O), 32'(e.mis));
          check("wb_regi", 32'(RegI_Wr_En_O), 32'(e.regi));
          check("wb_regf", 32'(RegF_Wr_En_O), 32'(e.regf));
          check("wb_load_data", load_data_O, e.ld);
          if (!e.mis) begin
            check("wb_pc", PC_O, e.pc);
            check("wb_alu", alu_result_O, e.alu);
            check("wb_isrc", 32'(iSrc_to_Reg_O), 32'(e.isrc));
            check("wb_fsrc", 32'(fSrc_to_Reg_O), 32'(e.fsrc));
            check("wb_rd", 32'(mem_wb_rd), 32'(e.rd));
          end
        end
      end
    end
  end

  // Memory responder with random ready/rvalid latency; checks each accepted request.
  initial begin
    logic        in_req, rd_pending;
    int          rdy_wait, rv_wait;
    logic [31:0] rd_word;
    rq_t         r;
    in_req = 0; rd_pending = 0; rdy_wait = 0; rv_wait = 0; rd_word = '0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
    forever begin
      @(negedge CLK);
      dmem_ready = 0; dmem_rvalid = 0;
      if (rst) begin
        in_req = 0; rd_pending = 0;
      end else if (rd_pending) begin
        if (rv_wait == 0) begin
          dmem_rvalid = 1; dmem_rdata = rd_word; rd_pending = 0;
        end else begin
          rv_wait--; dmem_rdata = $urandom;
        end
      end else if (dmem_req && !hold_ready) begin
        if (!in_req) begin in_req = 1; rdy_wait = $urandom_range(0, 2); end
        if (rdy_wait == 0) begin
          dmem_ready = 1; in_req = 0;
          if (rq_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rq_unexpected: got addr %08h we %0b expected no request", dmem_addr, dmem_we);
          end else begin
            r = rq_q.pop_front();
            check("rq_we", 32'(dmem_we), 32'(r.we));
            check("rq_addr", dmem_addr, r.addr);
            check("rq_be", 32'(dmem_be), 32'(r.be));
            if (r.we) check("rq_wdata", dmem_wdata, r.wdata);
          end
          if (dmem_we) begin
            for (int k = 0; k < 4; k++)
              if (dmem_be[k]) dmem[dmem_addr[7:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
          end else begin
            rd_pending = 1; rv_wait = $urandom_range(0, 2); rd_word = dmem[dmem_addr[7:2]];
          end
        end else begin
          rdy_wait--;
          if ($urandom_range(0, 1) == 1) begin dmem_rvalid = 1; dmem_rdata = $urandom; end
        end
      end
    end
  end

  task automatic drive_idle();
    PC_I = '0; alu_result_I = '0; store_to_mem_I = '0; MEM_Rd_En_I = 0; MEM_Wr_En_I = 0;
    LB_I = 0; LH_I = 0; SB_I = 0; SH_I = 0; LU_I = 0; RegI_Wr_En_I = 0; RegF_Wr_En_I = 0;
    iSrc_to_Reg_I = '0; fSrc_to_Reg_I = 0; ex_mem_rd = '0;
  endtask

  // Reference model for one instruction, then present it until the stage consumes it.
  task automatic issue(input op_t o);
    logic        is_mem, load, mis, s;
    int          off, base8, cyc;
    logic [31:0] val;
    rq_t         r;
    wb_t         w;
    is_mem = o.rd_en | o.wr_en;
    load   = o.rd_en & ~o.wr_en;
    off    = int'(o.addr % 4);
    mis    = is_mem && ((o.addr % o.size) != 0);
    base8  = int'(o.addr[7:0]);
    val    = '0;
    if (is_mem && !mis) begin
      r.we = o.wr_en; r.addr = o.addr - 32'(off); r.be = '0; r.wdata = '0;
      for (int k = 0; k < 4; k++) begin
        r.be[k] = (k >= off) && (k < off + o.size);
        r.wdata[8*k +: 8] = o.sdata[8*(k % o.size) +: 8];
      end
      rq_q.push_back(r);
      for (int i = 0; i < o.size; i++) begin
        if (o.wr_en) ref_mem[base8 + i] = o.sdata[8*i +: 8];
        else         val = val | (32'(ref_mem[base8 + i]) << (8*i));
      end
      if (load && !o.lu && o.size < 4 && val >= (32'd1 << (8*o.size - 1)))
        val = val - (32'd1 << (8*o.size));
    end
    w.pc = o.pc; w.alu = o.addr; w.ld = load ? val : '0; w.isrc = o.isrc; w.fsrc = o.fsrc;
    w.rd = o.rd; w.mis = mis; w.regi = o.regi & ~mis; w.regf = o.regf & ~mis;
    if (o.regi || o.regf || mis) wb_q.push_back(w);

    PC_I = o.pc; alu_result_I = o.addr; store_to_mem_I = o.sdata;
    MEM_Rd_En_I = o.rd_en; MEM_Wr_En_I = o.wr_en; LU_I = o.lu;
    LB_I = load && o.size == 1; LH_I = load && o.size == 2;
    SB_I = o.wr_en && o.size == 1; SH_I = o.wr_en && o.size == 2;
    RegI_Wr_En_I = o.regi; RegF_Wr_En_I = o.regf; iSrc_to_Reg_I = o.isrc;
    fSrc_to_Reg_I = o.fsrc; ex_mem_rd = o.rd;
    cyc = 0;
    forever begin
      @(negedge CLK);
      if (cyc == 0) check("stall_on_issue", 32'(mem_stall), 32'(is_mem && !mis));
      s = mem_stall;
      @(posedge CLK); #1;
      if (!s) break;
      cyc++;
      if (cyc > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL stall_timeout: got stall after %0d cycles expected release", cyc);
        break;
      end
    end
  endtask

  function automatic op_t mk(input logic [31:0] pc, addr, sdata, input logic rd_en, wr_en,
                             input int size, input logic lu, regi, regf, input logic [4:0] rd);
    op_t o;
    o.pc = pc; o.addr = addr; o.sdata = sdata; o.rd_en = rd_en; o.wr_en = wr_en; o.size = size;
    o.lu = lu; o.regi = regi; o.regf = regf; o.isrc = 2'(rd); o.fsrc = rd[0]; o.rd = rd;
    return o;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int  kind;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)
      dmem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    rst = 1; drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_dmem_req", 32'(dmem_req), 0);
    check("rst_dmem_be", 32'(dmem_be), 0);
    check("rst_regi", 32'(RegI_Wr_En_O), 0);
    check("rst_pc", PC_O, 0);
    check("rst_misalign", 32'(misalign_O), 0);
    @(posedge CLK); #1 rst = 0;

    // Reset abandons a load stuck waiting for ready.
    hold_ready = 1;
    PC_I = 32'h44; alu_result_I = 32'h40; MEM_Rd_En_I = 1; RegI_Wr_En_I = 1; ex_mem_rd = 5'd7;
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    check("mid_req", 32'(dmem_req), 1);
    check("mid_stall", 32'(mem_stall), 1);
    @(posedge CLK); #1 rst = 1; drive_idle();
    @(posedge CLK); #1 rst = 0; hold_ready = 0;
    @(negedge CLK);
    check("abort_req", 32'(dmem_req), 0);
    check("abort_stall", 32'(mem_stall), 0);
    check("abort_addr", dmem_addr, 0);
    check("abort_regi", 32'(RegI_Wr_En_O), 0);
    check("abort_ld", load_data_O, 0);
    @(posedge CLK); #1;

    issue(mk(32'h100, 32'h1234, 0, 0, 0, 4, 0, 1, 0, 5'd5));
    issue(mk(32'h104, 32'h1003, 32'h000000A5, 0, 1, 1, 0, 0, 0, 5'd0));
    issue(mk(32'h108, 32'h2000, 32'h80011234, 0, 1, 4, 0, 0, 0, 5'd0));
    issue(mk(32'h10C, 32'h2002, 0, 1, 0, 2, 0, 1, 0, 5'd9));
    issue(mk(32'h110, 32'h2002, 0, 1, 0, 2, 1, 1, 0, 5'd10));
    issue(mk(32'h114, 32'h0000, 32'h00007F00, 0, 1, 4, 0, 0, 0, 5'd0));
    issue(mk(32'h118, 32'h0001, 0, 1, 0, 1, 0, 1, 0, 5'd11));
    issue(mk(32'h11C, 32'h0006, 0, 1, 0, 4, 0, 1, 0, 5'd12));
    issue(mk(32'h120, 32'hCAFE0000, 0, 0, 0, 4, 0, 1, 0, 5'd13));
    issue(mk(32'h124, 32'h2000, 0, 1, 0, 4, 0, 1, 0, 5'd14));
    issue(mk(32'h128, 32'hBEEF0000, 0, 0, 0, 4, 0, 1, 0, 5'd15));
    issue(mk(32'h12C, 32'h0012, 32'h0000C3D2, 1, 1, 2, 0, 0, 0, 5'd0));
    issue(mk(32'h130, 32'h0012, 0, 1, 0, 2, 1, 0, 1, 5'd16));

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      o = mk($urandom, $urandom, $urandom, kind == 1 || kind == 3, kind >= 2,
             1 << $urandom_range(0, 2), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      if (kind >= 2) begin o.regi = 0; o.regf = 0; end
      if (kind == 1) o.regi = ~o.regf;
      o.isrc = 2'($urandom);
      issue(o);
    end

    drive_idle();
    repeat (20) @(posedge CLK);
    check("wb_queue_drained", 32'(wb_q.size()), 0);
    check("rq_queue_drained", 32'(rq_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit. It consumes the EX/MEM pipeline register outputs (address, store data, memory enables, LB/LH/SB/SH qualifiers, writeback controls) and runs the access on the data-memory request/ready interface.
- It aligns and extends load data, generates byte enables for stores and stalls the upstream pipeline while an access is in flight.
- It registers results into the MEM/WB boundary.

Parameters:
- XLEN, 32, integer datapath / address width
- FLEN, 32, FP register width (writeback controls only)

Ports:
- CLK  in  1  clock
- rst  in  1  synchronous active-high reset
- PC_I  in  32  PC of instruction in MEM
- alu_result_I  in  XLEN  effective address / ALU result
- store_to_mem_I  in  XLEN  store data
- MEM_Rd_En_I  in  1  load
- MEM_Wr_En_I  in  1  store
- LB_I, LH_I, SB_I, SH_I  in  1 each  byte/half qualifiers; all low = word
- LU_I  in  1  zero-extend load (LBU/LHU)
- RegI_Wr_En_I, RegF_Wr_En_I  in  1 each  regfile write enables
- iSrc_to_Reg_I  in  2  integer writeback select
- fSrc_to_Reg_I  in  1  FP writeback select
- ex_mem_rd  in  5  destination register
- dmem_req  out  1  request valid
- dmem_we  out  1  write
- dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read word
- mem_stall  out  1  hold IF..EX/MEM
- PC_O  out  32
- load_data_O  out  XLEN  extended load result
- alu_result_O  out  XLEN
- RegI_Wr_En_O, RegF_Wr_En_O  out  1 each
- iSrc_to_Reg_O  out  2
- fSrc_to_Reg_O  out  1
- mem_wb_rd  out  5
- misalign_O  out  1  misaligned-access flag, one cycle

Behaviour:
- Reset (rst=1 at posedge): FSM=IDLE. Every output register is 0, including dmem_req, dmem_we, dmem_be, all MEM/WB outputs and misalign_O. Reset mid-access abandons the access; no writeback.
- Misalignment: misaligned when (LH|SH) and addr[0]=1, or word access and addr[1:0]≠0.
  - A misaligned op issues no request and no stall.
  - It produces a MEM/WB bubble (RegI/RegF_Wr_En_O=0) with misalign_O=1 for one cycle.
- FSM IDLE:
  - Aligned mem op: mem_stall=1 combinationally. Register dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata, latch all EX/MEM controls → REQ.
  - No mem op: pass-through; MEM/WB registers capture inputs next edge, 1-cycle latency.
- REQ: hold dmem_req and all dmem_* stable until dmem_ready=1; mem_stall=1. On accept, drop dmem_req; store → DONE, load → WAIT.
- WAIT: mem_stall=1. dmem_rvalid is ignored before accept. On dmem_rvalid=1, latch extended data → DONE.
- DONE: mem_stall=0 for this cycle. MEM/WB registers capture the latched controls plus load_data at the edge → IDLE. Minimum store = 3 cycles, load = 4 cycles with zero-wait memory.
- While mem_stall=1, MEM/WB outputs hold a bubble (write enables 0); inputs are not resampled (upstream holds).
- Byte enables / wdata:
  - SB: be=1<<addr[1:0], wdata=byte replicated ×4.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata=half replicated ×2.
  - Word: be=4'b1111. Loads drive be per size too.
- Load extraction: byte=rdata>>(8*addr[1:0]); half=rdata>>(16*addr[1]). Sign-extend unless LU_I=1. Word passes unchanged.
- Both MEM_Rd_En_I and MEM_Wr_En_I high: treated as store.
- load_data_O=0 for non-load instructions.

Test Plan:
- Reset: assert rst during REQ with dmem_ready=0 → next cycle dmem_req=0, mem_stall=0, all outputs 0, FSM IDLE.
- SB addr=0x1003 data=0x000000A5 → dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5. mem_stall high 2 cycles with ready on first REQ cycle; RegI_Wr_En_O=0.
- LH addr=0x2002, rdata=0x8001_1234, 2-cycle ready wait, rvalid 1 cycle later → load_data_O=0xFFFF8001. With LU_I=1 → 0x00008001. Stall holds through wait.
- LB addr=0x0001 rdata=0x0000_7F00 → load_data_O=0x0000007F. mem_wb_rd, PC_O equal the latched values.
- Word load addr=0x0006 → no dmem_req, misalign_O=1 one cycle, RegI_Wr_En_O=0, mem_stall=0.
- Back-to-back ALU op, load, ALU op → ALU results appear at 1-cycle latency; the load's result appears in DONE+1; the second ALU op follows the next cycle with no loss or duplication.
